// File: rtl/cdce_pkg.sv
// Shared constants for the CDCE62005 serial interface: word width, recovery
// length and the 3-bit state encoding used by the shift engine.
package cdce_pkg;

  localparam int CDCE_WORD_W   = 32;
  localparam int RECOVER_TICKS = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_RECOVER  = 3'd5;

endpackage

// File: rtl/cdce_clk_divider.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and pulses tick on the last
// count; clear holds the counter at zero so every transfer starts phase-aligned.
module cdce_clk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear || count == LAST) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/cdce_serial_interface.sv
// LSB-first 3-wire SPI shift engine for CDCE62005 register words.
// Define CDCE_READBACK_EN to add spi_miso capture with read_data/read_valid.
module cdce_serial_interface
  import cdce_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_transaction,
  input  logic [CDCE_WORD_W-1:0] cdce_command,
  output logic                   serial_ready,
  output logic                   spi_clk,
  output logic                   spi_le,
  output logic                   spi_mosi
`ifdef CDCE_READBACK_EN
  ,
  input  logic                   spi_miso,
  output logic [CDCE_WORD_W-1:0] read_data,
  output logic                   read_valid
`endif
);

  localparam logic [1:0] REC_LAST = 2'(RECOVER_TICKS);

  logic [2:0]             state;
  logic [CDCE_WORD_W-1:0] shift_reg;
  logic [4:0]             bit_cnt;
  logic [1:0]             rec_cnt;
  logic                   tick;

  cdce_clk_divider #(.CLK_DIV(CLK_DIV)) u_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .tick    (tick)
  );

  // IDLE only accepts a start once serial_ready is already visible, so the
  // cycle in which RECOVER hands back to IDLE never launches a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= 5'd0;
      rec_cnt      <= 2'd0;
      serial_ready <= 1'b1;
      spi_clk      <= 1'b0;
      spi_le       <= 1'b1;
      spi_mosi     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!serial_ready) begin
            serial_ready <= 1'b1;
          end else if (start_transaction) begin
            shift_reg    <= cdce_command;
            bit_cnt      <= 5'd0;
            serial_ready <= 1'b0;
            spi_le       <= 1'b0;
            spi_clk      <= 1'b0;
            spi_mosi     <= cdce_command[0];
            state        <= ST_SETUP;
          end
        end
        ST_SETUP, ST_SHIFT_LO: begin
          if (tick) begin
            spi_clk <= 1'b1;
            state   <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            spi_clk   <= 1'b0;
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              state <= ST_HOLD;
            end else begin
              spi_mosi <= shift_reg[1];
              state    <= ST_SHIFT_LO;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            spi_le   <= 1'b1;
            spi_mosi <= 1'b0;
            rec_cnt  <= 2'd0;
            state    <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (tick) begin
            if (rec_cnt == REC_LAST) begin
              state <= ST_IDLE;
            end else begin
              rec_cnt <= rec_cnt + 2'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CDCE_READBACK_EN
  logic [CDCE_WORD_W-1:0] capture;

  // MISO is taken on each spi_clk falling edge; inserting at the MSB leaves
  // the first received bit in bit 0 after 32 shifts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture    <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      if (state == ST_SHIFT_HI && tick) begin
        capture <= {spi_miso, capture[CDCE_WORD_W-1:1]};
      end
      if (state == ST_HOLD && tick) begin
        read_data  <= capture;
        read_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdce_serial_interface.sv
// Self-checking bench for cdce_serial_interface: a negedge monitor rebuilds
// each serial word from spi_clk rising edges and checks it against a queue.
module tb_cdce_serial_interface;

  localparam int CLK_DIV   = 4;
  localparam int LE_LOW    = 65 * CLK_DIV;
  localparam int READY_LAT = 68 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_transaction = 1'b0;
  logic [31:0] cdce_command = 32'd0;
  logic        serial_ready;
  logic        spi_clk;
  logic        spi_le;
  logic        spi_mosi;
`ifdef CDCE_READBACK_EN
  logic        spi_miso = 1'b0;
  logic [31:0] read_data;
  logic        read_valid;
  logic [31:0] rb_word = 32'h1234_5678;
  int          rv_count = 0;
`endif

  always #5 clk = ~clk;

  cdce_serial_interface #(.CLK_DIV(CLK_DIV)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_transaction (start_transaction),
    .cdce_command      (cdce_command),
    .serial_ready      (serial_ready),
    .spi_clk           (spi_clk),
    .spi_le            (spi_le),
    .spi_mosi          (spi_mosi)
`ifdef CDCE_READBACK_EN
    ,
    .spi_miso          (spi_miso),
    .read_data         (read_data),
    .read_valid        (read_valid)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] rx_word = 32'd0;
  logic        prev_sclk = 1'b0;
  logic        prev_le = 1'b1;
  bit          in_word = 1'b0;
  bit          seen_word = 1'b0;
  int          rx_bits = 0;
  int          le_low_cnt = 0;
  int          le_high_cnt = 0;
  int          words_done = 0;
  int          words_sent = 0;
  int          idle_rises = 0;

  // Protocol-level monitor: bits are whatever MOSI holds while spi_clk is
  // high inside an spi_le-low window; the window closing completes a word.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_word   = 1'b0;
      seen_word = 1'b0;
      rx_bits   = 0;
      prev_sclk = 1'b0;
      prev_le   = 1'b1;
    end else begin
      if (spi_clk && !prev_sclk) begin
        if (!spi_le && in_word) begin
          if (rx_bits < 32) rx_word[rx_bits] = spi_mosi;
          rx_bits++;
`ifdef CDCE_READBACK_EN
          if (rx_bits <= 32) spi_miso = rb_word[rx_bits-1];
`endif
        end else begin
          idle_rises++;
        end
      end
      if (!spi_le && prev_le) begin
        if (seen_word)
          checkOutput("le_gap", (le_high_cnt >= 2 * CLK_DIV) ? 32'd1 : 32'd0, 32'd1);
        in_word    = 1'b1;
        rx_bits    = 0;
        rx_word    = 32'd0;
        le_low_cnt = 0;
      end
      if (!spi_le) le_low_cnt++;
      else         le_high_cnt++;
`ifdef CDCE_READBACK_EN
      if (read_valid) rv_count++;
`endif
      if (spi_le && !prev_le && in_word) begin
        in_word     = 1'b0;
        seen_word   = 1'b1;
        le_high_cnt = 0;
        words_done++;
        checkOutput("bit_count", 32'(rx_bits), 32'd32);
        checkOutput("le_low_len", 32'(le_low_cnt), 32'(LE_LOW));
        if (exp_q.size() == 0) checkOutput("unexpected_word", 32'd1, 32'd0);
        else                   checkOutput("serial_word", rx_word, exp_q.pop_front());
`ifdef CDCE_READBACK_EN
        checkOutput("read_valid", 32'(read_valid), 32'd1);
        checkOutput("read_data", read_data, rb_word);
`endif
      end
      prev_sclk = spi_clk;
      prev_le   = spi_le;
    end
  end

  // Sends one word when ready; poke_cycle > 0 pulses a second start that many
  // clocks after acceptance, which the DUT must ignore.
  task automatic applyStimulus(input logic [31:0] word, input int poke_cycle,
                               input logic [31:0] poke_word);
    int guard = 0;
    int cycles = 0;
    @(negedge clk);
    while (!serial_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_before_start", 32'(serial_ready), 32'd1);
    start_transaction = 1'b1;
    cdce_command      = word;
    exp_q.push_back(word);
    words_sent++;
    @(posedge clk);
    #1;
    start_transaction = 1'b0;
    cdce_command      = $urandom;
    checkOutput("ready_fall", 32'(serial_ready), 32'd0);
    checkOutput("le_fall", 32'(spi_le), 32'd0);
    while (!serial_ready && cycles < 4 * READY_LAT) begin
      @(posedge clk);
      cycles++;
      #1;
      if (cycles == poke_cycle) begin
        start_transaction = 1'b1;
        cdce_command      = poke_word;
      end else begin
        start_transaction = 1'b0;
      end
    end
    start_transaction = 1'b0;
    checkOutput("ready_latency", 32'(cycles), 32'(READY_LAT));
  endtask

  initial begin
    int guard;
    int done_before;

    #23;
    checkOutput("rst_ready", 32'(serial_ready), 32'd1);
    checkOutput("rst_le", 32'(spi_le), 32'd1);
    checkOutput("rst_sclk", 32'(spi_clk), 32'd0);
    checkOutput("rst_mosi", 32'(spi_mosi), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("idle_no_sclk", 32'(idle_rises), 32'd0);
    checkOutput("idle_le", 32'(spi_le), 32'd1);

    applyStimulus(32'h8184_0320, 0, 32'd0);
    applyStimulus(32'hA5A5_5A5A, 100, 32'hFFFF_FFFF);

    // A start landing while IDLE is re-entered but ready is not yet visible.
    applyStimulus($urandom, READY_LAT - 1, $urandom);
    done_before = words_done;
    repeat (40) @(negedge clk);
    checkOutput("no_extra_transfer", 32'(words_done), 32'(done_before));
    checkOutput("le_idle_after", 32'(spi_le), 32'd1);

    applyStimulus(32'h0000_0001, 0, 32'd0);
    applyStimulus(32'h8000_0000, 0, 32'd0);
    applyStimulus(32'hFFFF_FFFF, 0, 32'd0);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      applyStimulus($urandom, 0, 32'd0);
    end

    @(negedge clk);
    start_transaction = 1'b1;
    cdce_command      = $urandom;
    @(posedge clk);
    #1;
    start_transaction = 1'b0;
    guard = 0;
    while (rx_bits < 11 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reached_bit10", (rx_bits >= 11) ? 32'd1 : 32'd0, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_le", 32'(spi_le), 32'd1);
    checkOutput("abort_sclk", 32'(spi_clk), 32'd0);
    checkOutput("abort_ready", 32'(serial_ready), 32'd1);
    checkOutput("abort_mosi", 32'(spi_mosi), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus($urandom, 0, 32'd0);

    repeat (10) @(negedge clk);
    checkOutput("words_done", 32'(words_done), 32'(words_sent));
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef CDCE_READBACK_EN
    checkOutput("read_valid_pulses", 32'(rv_count), 32'(words_done));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
